// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module : usb_pkg
// Shared PID codes, transaction states and helpers for the transaction path.
// Rev    : 1.0
// ============================================================================
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } usb_pid_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_SEND_HS   = 2'd2
  } txn_state_e;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_toggle_tbl.sv
`default_nettype none
// ============================================================================
// Module : usb_toggle_tbl
// Per-endpoint DATA0/DATA1 expectation bits: read, flip, force-to-DATA0.
// Rev    : 1.0
// ============================================================================
module usb_toggle_tbl #(
  parameter int NUM_EP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_rd_idx,
  input  logic       i_flip_en,
  input  logic [3:0] i_flip_idx,
  input  logic       i_clr_en,
  input  logic [3:0] i_clr_idx,
  output logic       o_rd_val
);

  logic [NUM_EP-1:0] r_bits;
  logic [NUM_EP-1:0] w_clr_mask;
  logic [NUM_EP-1:0] w_flip_mask;
  logic [15:0]       w_all;

  always_comb begin
    w_clr_mask  = '0;
    w_flip_mask = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (i_clr_en && (i_clr_idx == 4'(i)))
        w_clr_mask[i] = 1'b1;
      if (i_flip_en && (i_flip_idx == 4'(i)))
        w_flip_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_bits <= '0;
    else
      r_bits <= (r_bits & ~w_clr_mask) ^ w_flip_mask;
  end

  // Unimplemented endpoints read as DATA0; the controller stalls them anyway.
  assign w_all    = 16'(r_bits);
  assign o_rd_val = w_all[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/usb_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : usb_txn_ctrl
// Device-side OUT/SETUP/IN transaction sequencer with toggle check and handshake.
// Rev    : 1.0
// ============================================================================
module usb_txn_ctrl #(
  parameter int NUM_EP      = 4,
  parameter int TIMEOUT_CYC = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [3:0] pkt_pid,
  input  logic [6:0] pkt_addr,
  input  logic [3:0] pkt_endp,
  input  logic       pkt_err,
  input  logic [6:0] dev_addr,
  input  logic       buf_ready,
  input  logic       hs_done,
  output logic       hs_req,
  output logic [3:0] hs_pid,
  output logic       data_commit,
  output logic       data_drop,
  output logic [3:0] txn_endp,
  output logic       timeout,
  output logic       busy
);
  import usb_pkg::*;

  localparam int                 c_tmr_w  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_tmr_w-1:0] c_tc     = c_tmr_w'(TIMEOUT_CYC - 1);
  localparam logic [4:0]         c_num_ep = 5'(NUM_EP);

  txn_state_e         r_state, w_state_nxt;
  logic [c_tmr_w-1:0] r_timer, w_timer_nxt;
  logic [3:0]         r_endp, w_endp_nxt;
  logic               r_setup, w_setup_nxt;
  logic [3:0]         r_hs_pid, w_hs_pid_nxt;
  logic               r_commit, w_commit_nxt;
  logic               r_drop, w_drop_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_flip, w_force, w_tgl, w_addr_hit, w_ep_ok;

  usb_toggle_tbl #(.NUM_EP(NUM_EP)) u_toggle_tbl (
    .clk        (clock),
    .rst        (reset),
    .i_rd_idx   (r_endp),
    .i_flip_en  (w_flip),
    .i_flip_idx (r_endp),
    .i_clr_en   (w_force),
    .i_clr_idx  (pkt_endp),
    .o_rd_val   (w_tgl)
  );

  assign w_addr_hit = pkt_valid && !pkt_err && (pkt_addr == dev_addr);
  assign w_ep_ok    = ({1'b0, r_endp} < c_num_ep);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_endp    <= '0;
      r_setup   <= 1'b0;
      r_hs_pid  <= '0;
      r_commit  <= 1'b0;
      r_drop    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_endp    <= w_endp_nxt;
      r_setup   <= w_setup_nxt;
      r_hs_pid  <= w_hs_pid_nxt;
      r_commit  <= w_commit_nxt;
      r_drop    <= w_drop_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_endp_nxt    = r_endp;
    w_setup_nxt   = r_setup;
    w_hs_pid_nxt  = r_hs_pid;
    w_commit_nxt  = 1'b0;
    w_drop_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_flip        = 1'b0;
    w_force       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_addr_hit && ((pkt_pid == PID_OUT) || (pkt_pid == PID_SETUP))) begin
          w_endp_nxt  = pkt_endp;
          w_setup_nxt = (pkt_pid == PID_SETUP);
          w_force     = (pkt_pid == PID_SETUP);
          w_timer_nxt = '0;
          w_state_nxt = ST_WAIT_DATA;
        end else if (w_addr_hit && (pkt_pid == PID_IN)) begin
          w_hs_pid_nxt = PID_NAK;
          w_state_nxt  = ST_SEND_HS;
        end
      end
      ST_WAIT_DATA: begin
        // A packet arriving on the terminal-count cycle wins over the timeout.
        if (pkt_valid) begin
          w_state_nxt = ST_IDLE;
          if (is_data_pid(pkt_pid)) begin
            if (pkt_err) begin
              w_drop_nxt = 1'b1;
            end else if (!w_ep_ok) begin
              w_drop_nxt   = 1'b1;
              w_hs_pid_nxt = PID_STALL;
              w_state_nxt  = ST_SEND_HS;
            end else if (w_tgl != pkt_pid[3]) begin
              // Retransmission of a packet already taken: ACK it again.
              w_drop_nxt   = 1'b1;
              w_hs_pid_nxt = PID_ACK;
              w_state_nxt  = ST_SEND_HS;
            end else if (buf_ready || r_setup) begin
              w_commit_nxt = 1'b1;
              w_flip       = 1'b1;
              w_hs_pid_nxt = PID_ACK;
              w_state_nxt  = ST_SEND_HS;
            end else begin
              w_drop_nxt   = 1'b1;
              w_hs_pid_nxt = PID_NAK;
              w_state_nxt  = ST_SEND_HS;
            end
          end
        end else if (r_timer == c_tc) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_SEND_HS: begin
        if (hs_done)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign hs_req      = (r_state == ST_SEND_HS);
  assign busy        = (r_state != ST_IDLE);
  assign hs_pid      = r_hs_pid;
  assign data_commit = r_commit;
  assign data_drop   = r_drop;
  assign timeout     = r_timeout;
  assign txn_endp    = r_endp;

endmodule
`default_nettype wire

// File: tb/tb_usb_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_usb_txn_ctrl
// Directed and randomized transactions against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_usb_txn_ctrl;
  import usb_pkg::*;

  localparam int         NUM_EP      = 4;
  localparam int         TIMEOUT_CYC = 18;
  localparam logic [6:0] DEV         = 7'd5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0, pkt_err = 1'b0, buf_ready = 1'b0, hs_done = 1'b0;
  logic [3:0] pkt_pid = 4'h0, pkt_endp = 4'h0;
  logic [6:0] pkt_addr = 7'h0, dev_addr = DEV;
  logic       hs_req, data_commit, data_drop, timeout, busy;
  logic [3:0] hs_pid, txn_endp;

  int checks = 0;
  int errors = 0;
  bit model_tgl [16];

  typedef struct {
    bit         commit;
    bit         drop;
    bit         hs;
    logic [3:0] pid;
  } exp_t;

  always #5 clock = ~clock;

  usb_txn_ctrl #(.NUM_EP(NUM_EP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .pkt_pid(pkt_pid),
    .pkt_addr(pkt_addr), .pkt_endp(pkt_endp), .pkt_err(pkt_err), .dev_addr(dev_addr),
    .buf_ready(buf_ready), .hs_done(hs_done), .hs_req(hs_req), .hs_pid(hs_pid),
    .data_commit(data_commit), .data_drop(data_drop), .txn_endp(txn_endp),
    .timeout(timeout), .busy(busy)
  );

  // Outcome of a DATA packet for the open transaction; updates the toggle model.
  function automatic exp_t model_data(input logic [3:0] endp, input bit setup,
                                      input logic [3:0] pid, input bit err, input bit rdy);
    exp_t e;
    bit   want;
    e = '{1'b0, 1'b0, 1'b0, 4'h0};
    if (pid != PID_DATA0 && pid != PID_DATA1) return e;
    e.drop = 1'b1;
    if (err) return e;
    e.hs = 1'b1;
    if (int'(endp) >= NUM_EP) begin
      e.pid = PID_STALL;
      return e;
    end
    want = model_tgl[endp];
    if ((pid == PID_DATA1) != want) begin
      e.pid = PID_ACK;
    end else if (rdy || setup) begin
      e.drop = 1'b0;
      e.commit = 1'b1;
      e.pid = PID_ACK;
      model_tgl[endp] = !want;
    end else begin
      e.pid = PID_NAK;
    end
    return e;
  endfunction

  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr,
                          input logic [3:0] endp, input bit err);
    @(negedge clock);
    pkt_valid = 1'b1; pkt_pid = pid; pkt_addr = addr; pkt_endp = endp; pkt_err = err;
    @(posedge clock); #1;
    pkt_valid = 1'b0; pkt_err = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic complete_hs(input int delay);
    idle_cycles(delay);
    @(negedge clock); hs_done = 1'b1;
    @(posedge clock); #1; hs_done = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    foreach (model_tgl[i]) model_tgl[i] = 1'b0;
    #1;
    checks++;
    if ({hs_req, data_commit, data_drop, timeout, busy} !== 5'b0 || hs_pid !== 4'h0 || txn_endp !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: outs=%b hs_pid=%h endp=%h, want all zero",
               {hs_req, data_commit, data_drop, timeout, busy}, hs_pid, txn_endp);
    end
  endtask

  task automatic test_commit_and_retx;
    exp_t e;
    send_pkt(PID_OUT, DEV, 4'd1, 1'b0);
    checks++;
    if (busy !== 1'b1 || txn_endp !== 4'd1) begin
      errors++; $display("FAIL out_token: busy=%b endp=%h, want 1/1", busy, txn_endp);
    end
    buf_ready = 1'b1;
    send_pkt(PID_DATA0, DEV, 4'd0, 1'b0);
    e = model_data(4'd1, 1'b0, PID_DATA0, 1'b0, 1'b1);
    checks++;
    if (data_commit !== 1'b1 || data_drop !== 1'b0 || hs_req !== 1'b1 || hs_pid !== PID_ACK) begin
      errors++; $display("FAIL first_data0: commit=%b drop=%b hs_req=%b pid=%h, want 1 0 1 2",
                         data_commit, data_drop, hs_req, hs_pid);
    end
    complete_hs(1);
    checks++;
    if (hs_req !== 1'b0 || busy !== 1'b0 || data_commit !== 1'b0) begin
      errors++; $display("FAIL hs_release: hs_req=%b busy=%b commit=%b, want 0 0 0", hs_req, busy, data_commit);
    end
    send_pkt(PID_OUT, DEV, 4'd1, 1'b0);
    send_pkt(PID_DATA0, DEV, 4'd0, 1'b0);
    e = model_data(4'd1, 1'b0, PID_DATA0, 1'b0, 1'b1);
    checks++;
    if (data_commit !== 1'b0 || data_drop !== 1'b1 || hs_pid !== PID_ACK || hs_req !== 1'b1) begin
      errors++; $display("FAIL retransmit: commit=%b drop=%b pid=%h, want 0 1 2", data_commit, data_drop, hs_pid);
    end
    complete_hs(0);
  endtask

  task automatic test_nak;
    exp_t e;
    send_pkt(PID_OUT, DEV, 4'd2, 1'b0);
    buf_ready = 1'b0;
    send_pkt(PID_DATA0, DEV, 4'd0, 1'b0);
    e = model_data(4'd2, 1'b0, PID_DATA0, 1'b0, 1'b0);
    checks++;
    if (data_drop !== 1'b1 || data_commit !== 1'b0 || hs_pid !== PID_NAK) begin
      errors++; $display("FAIL nak_busy: drop=%b commit=%b pid=%h, want 1 0 a", data_drop, data_commit, hs_pid);
    end
    complete_hs(2);
    send_pkt(PID_OUT, DEV, 4'd2, 1'b0);
    buf_ready = 1'b1;
    send_pkt(PID_DATA0, DEV, 4'd0, 1'b0);
    e = model_data(4'd2, 1'b0, PID_DATA0, 1'b0, 1'b1);
    checks++;
    if (data_commit !== 1'b1 || hs_pid !== PID_ACK) begin
      errors++; $display("FAIL nak_keeps_toggle: commit=%b pid=%h, want 1 2", data_commit, hs_pid);
    end
    complete_hs(0);
  endtask

  task automatic test_timeout;
    int first, pulses;
    bit early_idle;
    exp_t e;
    first = -1; pulses = 0; early_idle = 1'b0;
    send_pkt(PID_OUT, DEV, 4'd0, 1'b0);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); #1;
      if (timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c < TIMEOUT_CYC && busy !== 1'b1) early_idle = 1'b1;
      if (c == TIMEOUT_CYC && busy !== 1'b0) early_idle = 1'b1;
    end
    checks++;
    if (first != TIMEOUT_CYC || pulses != 1 || early_idle) begin
      errors++; $display("FAIL timeout_cycle: first=%0d pulses=%0d busy_bad=%0b, want %0d 1 0",
                         first, pulses, early_idle, TIMEOUT_CYC);
    end
    // DATA on the terminal-count cycle must still be taken.
    send_pkt(PID_OUT, DEV, 4'd0, 1'b0);
    idle_cycles(TIMEOUT_CYC - 1);
    buf_ready = 1'b1;
    send_pkt(PID_DATA1, DEV, 4'd0, 1'b0);
    e = model_data(4'd0, 1'b0, PID_DATA1, 1'b0, 1'b1);
    checks++;
    if (timeout !== 1'b0 || data_commit !== e.commit || hs_req !== 1'b1 || hs_pid !== e.pid) begin
      errors++; $display("FAIL timeout_race: timeout=%b commit=%b pid=%h, want 0 %b %h",
                         timeout, data_commit, hs_pid, e.commit, e.pid);
    end
    complete_hs(0);
  endtask

  task automatic test_setup;
    exp_t e;
    send_pkt(PID_SETUP, DEV, 4'd1, 1'b0);
    model_tgl[1] = 1'b0;
    buf_ready = 1'b0;
    send_pkt(PID_DATA0, DEV, 4'd0, 1'b0);
    e = model_data(4'd1, 1'b1, PID_DATA0, 1'b0, 1'b0);
    checks++;
    if (data_commit !== 1'b1 || data_drop !== 1'b0 || hs_pid !== PID_ACK) begin
      errors++; $display("FAIL setup_force: commit=%b drop=%b pid=%h, want 1 0 2", data_commit, data_drop, hs_pid);
    end
    complete_hs(0);
    send_pkt(PID_OUT, DEV, 4'd1, 1'b0);
    buf_ready = 1'b1;
    send_pkt(PID_DATA1, DEV, 4'd0, 1'b0);
    e = model_data(4'd1, 1'b0, PID_DATA1, 1'b0, 1'b1);
    checks++;
    if (data_commit !== 1'b1 || hs_pid !== PID_ACK) begin
      errors++; $display("FAIL setup_then_data1: commit=%b pid=%h, want 1 2", data_commit, hs_pid);
    end
    complete_hs(0);
  endtask

  task automatic test_stall_addr_reset;
    exp_t e;
    send_pkt(PID_OUT, DEV, 4'd7, 1'b0);
    send_pkt(PID_DATA0, DEV, 4'd0, 1'b0);
    e = model_data(4'd7, 1'b0, PID_DATA0, 1'b0, 1'b1);
    checks++;
    if (data_drop !== 1'b1 || hs_pid !== PID_STALL || hs_req !== 1'b1) begin
      errors++; $display("FAIL stall: drop=%b pid=%h hs_req=%b, want 1 e 1", data_drop, hs_pid, hs_req);
    end
    complete_hs(0);
    send_pkt(PID_OUT, 7'd6, 4'd1, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wrong_addr: busy=%b, want 0", busy);
    end
    send_pkt(PID_OUT, DEV, 4'd3, 1'b0);
    send_pkt(PID_DATA0, DEV, 4'd0, 1'b0);
    e = model_data(4'd3, 1'b0, PID_DATA0, 1'b0, 1'b1);
    complete_hs(0);
    send_pkt(PID_IN, DEV, 4'd0, 1'b0);
    send_pkt(PID_DATA1, DEV, 4'd0, 1'b0);
    checks++;
    if (hs_req !== 1'b1 || hs_pid !== PID_NAK || data_commit !== 1'b0 || data_drop !== 1'b0) begin
      errors++; $display("FAIL in_nak_hold: hs_req=%b pid=%h commit=%b drop=%b, want 1 a 0 0",
                         hs_req, hs_pid, data_commit, data_drop);
    end
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({hs_req, data_commit, data_drop, timeout, busy} !== 5'b0 || hs_pid !== 4'h0 || txn_endp !== 4'h0) begin
      errors++; $display("FAIL async_reset: outs=%b pid=%h endp=%h, want all zero",
                         {hs_req, data_commit, data_drop, timeout, busy}, hs_pid, txn_endp);
    end
    @(negedge clock); reset = 1'b0;
    foreach (model_tgl[i]) model_tgl[i] = 1'b0;
    send_pkt(PID_OUT, DEV, 4'd3, 1'b0);
    send_pkt(PID_DATA0, DEV, 4'd0, 1'b0);
    e = model_data(4'd3, 1'b0, PID_DATA0, 1'b0, 1'b1);
    checks++;
    if (data_commit !== 1'b1) begin
      errors++; $display("FAIL reset_toggles: commit=%b, want 1", data_commit);
    end
    complete_hs(0);
  endtask

  task automatic test_hs_done_outside;
    exp_t e;
    @(negedge clock); hs_done = 1'b1;
    @(negedge clock); hs_done = 1'b0;
    send_pkt(PID_OUT, DEV, 4'd0, 1'b0);
    @(negedge clock); hs_done = 1'b1;
    @(posedge clock); #1; hs_done = 1'b0;
    checks++;
    if (busy !== 1'b1 || hs_req !== 1'b0) begin
      errors++; $display("FAIL hs_done_in_wait: busy=%b hs_req=%b, want 1 0", busy, hs_req);
    end
    send_pkt(PID_DATA1, DEV, 4'd0, 1'b0);
    e = model_data(4'd0, 1'b0, PID_DATA1, 1'b0, 1'b1);
    idle_cycles(1);
    checks++;
    if (hs_req !== 1'b1 || hs_pid !== e.pid) begin
      errors++; $display("FAIL hs_after_stray_done: hs_req=%b pid=%h, want 1 %h", hs_req, hs_pid, e.pid);
    end
    complete_hs(0);
  endtask

  task automatic test_random(input int n);
    logic [3:0] toks [5];
    logic [3:0] dats [4];
    logic [3:0] tp, dp, endp;
    logic [6:0] addr;
    bit terr, derr, acc, innak, stable;
    int w, d;
    exp_t e;
    toks = '{PID_OUT, PID_SETUP, PID_IN, PID_DATA0, PID_ACK};
    dats = '{PID_DATA0, PID_DATA1, PID_ACK, PID_OUT};
    for (int k = 0; k < n; k++) begin
      tp   = toks[$urandom_range(0, 4)];
      addr = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : DEV;
      endp = 4'($urandom_range(0, 7));
      terr = ($urandom_range(0, 9) == 0);
      acc   = !terr && addr == DEV && (tp == PID_OUT || tp == PID_SETUP);
      innak = !terr && addr == DEV && tp == PID_IN;
      send_pkt(tp, addr, endp, terr);
      checks++;
      if (busy !== (acc || innak) || hs_req !== innak || (innak && hs_pid !== PID_NAK) ||
          (acc && txn_endp !== endp)) begin
        errors++; $display("FAIL rnd_token[%0d]: pid=%h busy=%b hs_req=%b hs_pid=%h endp=%h",
                           k, tp, busy, hs_req, hs_pid, txn_endp);
      end
      if (innak) complete_hs($urandom_range(0, 2));
      if (!acc) continue;
      if (tp == PID_SETUP && int'(endp) < NUM_EP) model_tgl[endp] = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        idle_cycles(TIMEOUT_CYC - 1);
        stable = (busy === 1'b1 && timeout === 1'b0);
        idle_cycles(1);
        checks++;
        if (!stable || timeout !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL rnd_timeout[%0d]: pre_ok=%b timeout=%b busy=%b, want 1 1 0", k, stable, timeout, busy);
        end
        continue;
      end
      w = ($urandom_range(0, 3) == 0) ? TIMEOUT_CYC - 1 : $urandom_range(0, TIMEOUT_CYC - 1);
      idle_cycles(w);
      dp = ($urandom_range(0, 9) == 0) ? dats[$urandom_range(2, 3)] : dats[$urandom_range(0, 1)];
      derr = ($urandom_range(0, 7) == 0);
      buf_ready = $urandom_range(0, 1);
      send_pkt(dp, DEV, 4'($urandom_range(0, 15)), derr);
      e = model_data(endp, tp == PID_SETUP, dp, derr, buf_ready);
      checks++;
      if (data_commit !== e.commit || data_drop !== e.drop || timeout !== 1'b0 ||
          hs_req !== e.hs || busy !== e.hs || (e.hs && hs_pid !== e.pid)) begin
        errors++; $display("FAIL rnd_data[%0d]: c=%b d=%b t=%b hs=%b pid=%h, want c=%b d=%b hs=%b pid=%h",
                           k, data_commit, data_drop, timeout, hs_req, hs_pid, e.commit, e.drop, e.hs, e.pid);
      end
      if (!e.hs) continue;
      d = $urandom_range(1, 3);
      stable = 1'b1;
      repeat (d) begin
        @(posedge clock); #1;
        if (hs_req !== 1'b1 || hs_pid !== e.pid || data_commit !== 1'b0 || data_drop !== 1'b0) stable = 1'b0;
      end
      complete_hs(0);
      checks++;
      if (!stable || hs_req !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rnd_hs[%0d]: hold_ok=%b hs_req=%b busy=%b, want 1 0 0", k, stable, hs_req, busy);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_commit_and_retx();
    test_nak();
    test_timeout();
    test_setup();
    test_stall_addr_reset();
    test_hs_done_outside();
    test_random(150);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
